adc_ltc2308_responder: RTL and testbench

- Behavioural-synthesizable SPI-side model of the LTC2308 8-channel 12-bit ADC.
- Responds to the adc_control master: takes ADC_SCLK, ADC_CS_N (CONVST) and ADC_DIN, and drives ADC_DOUT.
- Conversion data is taken from a parallel bus of per-channel values.
- Used in simulation benches and for FPGA loopback bring-up when no physical ADC is fitted.

---
 rtl/adc_ltc2308_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_adc_ltc2308_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module   : adc_ltc2308_responder
// Purpose  : SPI-side model of the LTC2308 8-channel 12-bit ADC. Answers the
//            adc_control master: a CONVST (ADC_CS_N) rising edge samples one
//            channel of CH_VALUES, and the result is then shifted out MSB
//            first on ADC_DOUT while six config bits are taken from ADC_DIN.
//            A committed config selects the conversion for the next frame.
// Ports    : CLOCK, RESET       system clock, synchronous active-high reset
//            ADC_SCLK/CS_N/DIN  master-side serial inputs (asynchronous)
//            ADC_DOUT           serial result, MSB first
//            CH_VALUES          8 x 12-bit channel values, CH n at [12n+11:12n]
//            BUSY               high while converting
//            FRAME_COUNT        completed 12-bit frames (wraps)
//            LAST_CONFIG        committed {S/D,O/S,S1,S0,UNI,SLP}
//            PROTO_ERR          sticky protocol-violation flag
// Options  : define ADC_RESP_PROTOCOL_CHECK_EN to enable PROTO_ERR detection;
//            otherwise PROTO_ERR is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module adc_ltc2308_responder #(
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        ADC_SCLK,
    input  logic        ADC_CS_N,
    input  logic        ADC_DIN,
    output logic        ADC_DOUT,
    input  logic [95:0] CH_VALUES,
    output logic        BUSY,
    output logic [15:0] FRAME_COUNT,
    output logic [5:0]  LAST_CONFIG,
    output logic        PROTO_ERR
);

    localparam int               c_cnt_w     = $clog2(CONV_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_conv_last = c_cnt_w'(CONV_CYCLES - 1);
    localparam logic [5:0]       c_cfg_reset = 6'b100010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONVERT = 3'd1,
        S_WAIT_CS = 3'd2,
        S_SHIFT   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic w_sclk, w_cs, w_din;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    // CS_N chain resets high (its idle level) so a master holding CONVST high
    // through reset does not look like a fresh rising edge afterwards.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_din_sync  <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], ADC_DIN};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_din       = r_din_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk &  r_sclk_prev;
    assign w_cs_rise   =  w_cs   & ~r_cs_prev;
    assign w_cs_fall   = ~w_cs   &  r_cs_prev;

    // ------------------------------------------------------------------
    // Conversion result: single-ended channel number is {S1,S0,O/S}
    // ------------------------------------------------------------------
    function automatic logic [11:0] f_result(input logic [5:0] cfg, input logic [95:0] vals);
        logic [2:0]  ch;
        logic [11:0] v;
        ch = {cfg[3], cfg[2], cfg[4]};
        v  = vals[12*ch +: 12];
        if (!cfg[5])
            v = 12'h000;
        else if (!cfg[1])
            v = v ^ 12'h800;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Main state machine
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [c_cnt_w-1:0]   r_conv_cnt;
    logic [11:0]          r_shift;
    logic [3:0]           r_k;
    logic [2:0]           r_cfg_cnt;
    logic [5:0]           r_cfg_shift;
    logic [5:0]           r_last_cfg;
    logic [15:0]          r_frame_count;
    logic                 r_dout;
    logic                 r_busy;
    logic [5:0]           w_cfg_next;

    // Config committed at CS_N rise only when a full 6-bit word arrived.
    assign w_cfg_next = (r_cfg_cnt == 3'd6) ? r_cfg_shift : r_last_cfg;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_conv_cnt    <= '0;
            r_shift       <= 12'h000;
            r_k           <= 4'd0;
            r_cfg_cnt     <= 3'd0;
            r_cfg_shift   <= 6'd0;
            r_last_cfg    <= c_cfg_reset;
            r_frame_count <= 16'd0;
            r_dout        <= 1'b0;
            r_busy        <= 1'b0;
        end else if (w_cs_rise) begin
            // CONVST wins over everything else, including an unfinished frame.
            r_last_cfg <= w_cfg_next;
            r_shift    <= f_result(w_cfg_next, CH_VALUES);
            r_cfg_cnt  <= 3'd0;
            r_k        <= 4'd0;
            r_dout     <= 1'b0;
            r_busy     <= 1'b1;
            r_conv_cnt <= '0;
            r_state    <= S_CONVERT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dout <= 1'b0;
                end
                S_CONVERT: begin
                    if (r_conv_cnt == c_conv_last) begin
                        r_busy     <= 1'b0;
                        r_conv_cnt <= '0;
                        if (!w_cs) begin
                            r_state <= S_SHIFT;
                            r_dout  <= r_shift[11];
                        end else begin
                            r_state <= S_WAIT_CS;
                        end
                    end else begin
                        r_conv_cnt <= r_conv_cnt + 1'b1;
                    end
                end
                S_WAIT_CS: begin
                    if (w_cs_fall) begin
                        r_state <= S_SHIFT;
                        r_dout  <= r_shift[11];
                        r_k     <= 4'd0;
                    end
                end
                S_SHIFT: begin
                    if (w_sclk_fall) begin
                        if (r_k == 4'd11) begin
                            r_dout        <= 1'b0;
                            r_k           <= 4'd12;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_state       <= S_DONE;
                        end else begin
                            r_k     <= r_k + 4'd1;
                            r_dout  <= r_shift[10];
                            r_shift <= {r_shift[10:0], 1'b0};
                        end
                    end
                    if (w_sclk_rise && (r_cfg_cnt < 3'd6)) begin
                        r_cfg_shift <= {r_cfg_shift[4:0], w_din};
                        r_cfg_cnt   <= r_cfg_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    r_dout <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ADC_DOUT    = r_dout;
    assign BUSY        = r_busy;
    assign FRAME_COUNT = r_frame_count;
    assign LAST_CONFIG = r_last_cfg;

`ifdef ADC_RESP_PROTOCOL_CHECK_EN
    logic r_proto_err;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_proto_err <= 1'b0;
        end else if (((r_state == S_CONVERT) && (w_sclk_rise || w_sclk_fall || w_cs_rise)) ||
                     ((r_state == S_SHIFT) && w_cs_rise && (r_k < 4'd12))) begin
            r_proto_err <= 1'b1;
        end
    end

    assign PROTO_ERR = r_proto_err;
`else
    assign PROTO_ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_ltc2308_responder
// Purpose  : Self-checking bench for adc_ltc2308_responder. Acts as the SPI
//            master and compares every frame with a behavioural model of the
//            converter (channel lookup table, bipolar offset arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_ltc2308_responder;

    localparam int CONV_CYCLES = 80;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;   // SCLK half period in CLOCK cycles
`ifdef ADC_RESP_PROTOCOL_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        ADC_SCLK;
    logic        ADC_CS_N;
    logic        ADC_DIN;
    logic [95:0] CH_VALUES;
    wire         ADC_DOUT;
    wire         BUSY;
    wire  [15:0] FRAME_COUNT;
    wire  [5:0]  LAST_CONFIG;
    wire         PROTO_ERR;

    adc_ltc2308_responder #(
        .CONV_CYCLES(CONV_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .ADC_SCLK   (ADC_SCLK),
        .ADC_CS_N   (ADC_CS_N),
        .ADC_DIN    (ADC_DIN),
        .ADC_DOUT   (ADC_DOUT),
        .CH_VALUES  (CH_VALUES),
        .BUSY       (BUSY),
        .FRAME_COUNT(FRAME_COUNT),
        .LAST_CONFIG(LAST_CONFIG),
        .PROTO_ERR  (PROTO_ERR)
    );

    always #10 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          ch_map [0:7] = '{0, 2, 4, 6, 1, 3, 5, 7};
    logic [5:0]  m_cfg;
    logic [11:0] m_res;
    int          m_frames;
    logic        m_proto;
    int          m_cap;
    logic [5:0]  m_shift_cfg;

    function automatic logic [11:0] ref_result(input logic [5:0] cfg, input logic [95:0] chv);
        int sel;
        int v;
        if (cfg[5] == 1'b0) return 12'h000;
        sel = cfg[4] * 4 + cfg[3] * 2 + cfg[2];
        v   = int'(chv[12*ch_map[sel] +: 12]);
        if (cfg[1] == 1'b0) v = (v + 2048) % 4096;
        return 12'(v);
    endfunction

    function automatic logic [95:0] rand_ch();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r;
    endfunction

    task automatic clk(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic set_ch(input int n, input logic [11:0] v);
        CH_VALUES[12*n +: 12] = v;
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        ADC_SCLK = 1'b0;
        ADC_CS_N = 1'b1;
        ADC_DIN  = 1'b0;
        clk(3);
        RESET = 1'b0;
        clk(2);
        m_cfg = 6'b100010; m_res = 12'h000; m_frames = 0; m_proto = 1'b0; m_cap = 0;
        m_shift_cfg = 6'd0;
    endtask

    task automatic cs_rise();
        if (ADC_CS_N) begin
            ADC_CS_N = 1'b0;
            clk(4);
        end
        ADC_CS_N = 1'b1;
        if (m_cap >= 6) m_cfg = m_shift_cfg;
        m_res = ref_result(m_cfg, CH_VALUES);
        m_cap = 0;
        clk(4);
    endtask

    task automatic cs_fall_wait();
        int n;
        ADC_CS_N = 1'b0;
        n = 0;
        while (BUSY === 1'b1 && n < 400) begin
            clk(1);
            n++;
        end
        if (n >= 400) begin
            errors++;
            $display("FAIL busy_timeout cycles=%0d limit=400", n);
        end
        checks++;
        clk(SYNC_STAGES + 4);
    endtask

    task automatic spi_bits(input logic [5:0] cfg, input int nbits, output logic [11:0] data);
        data = 12'h000;
        for (int i = 0; i < nbits; i++) begin
            ADC_DIN = (i < 6) ? cfg[5-i] : 1'b0;
            clk(HALF);
            data[11-i] = ADC_DOUT;
            ADC_SCLK = 1'b1;
            clk(HALF);
            ADC_SCLK = 1'b0;
        end
        clk(HALF);
        if (nbits >= 6) begin
            m_cap = 6;
            m_shift_cfg = cfg;
        end else begin
            m_cap = nbits;
        end
        if (nbits >= 12) m_frames++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        if (ADC_DOUT !== 1'b0) begin errors++; $display("FAIL reset_dout got=%b exp=0", ADC_DOUT); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++;
        if (FRAME_COUNT !== 16'd0) begin errors++; $display("FAIL reset_frames got=%0d exp=0", FRAME_COUNT); end
        checks++;
        if (LAST_CONFIG !== 6'b100010) begin errors++; $display("FAIL reset_cfg got=%b exp=100010", LAST_CONFIG); end
        checks++;
        if (PROTO_ERR !== 1'b0) begin errors++; $display("FAIL reset_proto got=%b exp=0", PROTO_ERR); end
        checks++;
    endtask

    task automatic test_basic();
        logic [11:0] d;
        CH_VALUES = rand_ch();
        set_ch(0, 12'hABC);
        cs_rise();
        cs_fall_wait();
        spi_bits(6'b100010, 12, d);
        if (d !== 12'hABC) begin errors++; $display("FAIL basic_data got=%h exp=abc", d); end
        checks++;
        if (FRAME_COUNT !== 16'd1) begin errors++; $display("FAIL basic_frames got=%0d exp=1", FRAME_COUNT); end
        checks++;
        cs_rise();
        if (LAST_CONFIG !== 6'b100010) begin errors++; $display("FAIL basic_cfg got=%b exp=100010", LAST_CONFIG); end
        checks++;
    endtask

    task automatic test_config_select();
        logic [11:0] d;
        set_ch(2, 12'h123);
        set_ch(1, 12'h456);
        cs_fall_wait();
        spi_bits(6'b110010, 12, d);
        if (d !== m_res) begin errors++; $display("FAIL cfgsel_frame1 got=%h exp=%h", d, m_res); end
        checks++;
        cs_rise();
        if (LAST_CONFIG !== 6'b110010) begin errors++; $display("FAIL cfgsel_cfg got=%b exp=110010", LAST_CONFIG); end
        checks++;
        cs_fall_wait();
        spi_bits(6'b100010, 12, d);
        if (d !== 12'h456) begin errors++; $display("FAIL cfgsel_frame2 got=%h exp=456", d); end
        checks++;
    endtask

    task automatic test_bipolar();
        logic [11:0] d;
        set_ch(0, 12'h000);
        cs_rise();
        cs_fall_wait();
        spi_bits(6'b100000, 12, d);
        if (d !== m_res) begin errors++; $display("FAIL bipolar_pre got=%h exp=%h", d, m_res); end
        checks++;
        cs_rise();
        cs_fall_wait();
        spi_bits(6'b100000, 12, d);
        if (d !== 12'h800) begin errors++; $display("FAIL bipolar_data got=%h exp=800", d); end
        checks++;
        if (LAST_CONFIG !== 6'b100000) begin errors++; $display("FAIL bipolar_cfg got=%b exp=100000", LAST_CONFIG); end
        checks++;
    endtask

    task automatic test_early_cs();
        logic [11:0] d;
        int          n;
        int          w;
        logic        dout_seen;
        do_reset();
        set_ch(0, 12'hC35);
        ADC_CS_N = 1'b0;
        clk(4);
        ADC_CS_N = 1'b1;
        m_res = ref_result(m_cfg, CH_VALUES);
        w = 0;
        while (BUSY !== 1'b1 && w < 10) begin clk(1); w++; end
        n = 0;
        dout_seen = 1'b0;
        while (BUSY === 1'b1 && n < 400) begin
            if (n == 18) ADC_CS_N = 1'b0;
            if (n == 30) ADC_SCLK = 1'b1;
            if (n == 40) ADC_SCLK = 1'b0;
            if (n == 50) ADC_SCLK = 1'b1;
            if (n == 60) ADC_SCLK = 1'b0;
            if (ADC_DOUT !== 1'b0) dout_seen = 1'b1;
            clk(1);
            n++;
        end
        m_proto = PCHK;
        if (n !== CONV_CYCLES) begin errors++; $display("FAIL early_busy_len got=%0d exp=%0d", n, CONV_CYCLES); end
        checks++;
        if (dout_seen !== 1'b0) begin errors++; $display("FAIL early_dout_in_convert got=%b exp=0", dout_seen); end
        checks++;
        clk(SYNC_STAGES + 4);
        spi_bits(6'b100010, 12, d);
        if (d !== 12'hC35) begin errors++; $display("FAIL early_data got=%h exp=c35", d); end
        checks++;
        if (PROTO_ERR !== m_proto) begin errors++; $display("FAIL early_proto got=%b exp=%b", PROTO_ERR, m_proto); end
        checks++;
    endtask

    task automatic test_abort();
        logic [11:0] d;
        logic [11:0] v;
        do_reset();
        v = 12'($urandom);
        set_ch(0, v);
        cs_rise();
        cs_fall_wait();
        spi_bits(6'b110111, 5, d);
        if (d[11:7] !== m_res[11:7]) begin errors++; $display("FAIL abort_bits got=%b exp=%b", d[11:7], m_res[11:7]); end
        checks++;
        cs_rise();
        m_proto = PCHK;
        if (FRAME_COUNT !== 16'd0) begin errors++; $display("FAIL abort_frames got=%0d exp=0", FRAME_COUNT); end
        checks++;
        if (LAST_CONFIG !== 6'b100010) begin errors++; $display("FAIL abort_cfg got=%b exp=100010", LAST_CONFIG); end
        checks++;
        if (PROTO_ERR !== m_proto) begin errors++; $display("FAIL abort_proto got=%b exp=%b", PROTO_ERR, m_proto); end
        checks++;
        cs_fall_wait();
        spi_bits(6'b100010, 12, d);
        if (d !== v) begin errors++; $display("FAIL abort_next_data got=%h exp=%h", d, v); end
        checks++;
        if (FRAME_COUNT !== 16'd1) begin errors++; $display("FAIL abort_next_frames got=%0d exp=1", FRAME_COUNT); end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [11:0] d;
        logic [11:0] v;
        cs_rise();
        cs_fall_wait();
        spi_bits(6'b110111, 7, d);
        RESET = 1'b1;
        clk(1);
        if (ADC_DOUT !== 1'b0) begin errors++; $display("FAIL midrst_dout got=%b exp=0", ADC_DOUT); end
        checks++;
        if (FRAME_COUNT !== 16'd0) begin errors++; $display("FAIL midrst_frames got=%0d exp=0", FRAME_COUNT); end
        checks++;
        if (LAST_CONFIG !== 6'b100010) begin errors++; $display("FAIL midrst_cfg got=%b exp=100010", LAST_CONFIG); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", BUSY); end
        checks++;
        RESET = 1'b0;
        m_cfg = 6'b100010; m_frames = 0; m_proto = 1'b0; m_cap = 0;
        clk(2);
        v = 12'($urandom);
        set_ch(0, v);
        cs_rise();
        cs_fall_wait();
        spi_bits(6'b100010, 12, d);
        if (d !== v) begin errors++; $display("FAIL midrst_next_data got=%h exp=%h", d, v); end
        checks++;
        if (PROTO_ERR !== 1'b0) begin errors++; $display("FAIL midrst_proto got=%b exp=0", PROTO_ERR); end
        checks++;
    endtask

    task automatic test_random();
        logic [11:0] d;
        logic [5:0]  cfg;
        for (int it = 0; it < 20; it++) begin
            cs_rise();
            if (LAST_CONFIG !== m_cfg) begin errors++; $display("FAIL rand_cfg it=%0d got=%b exp=%b", it, LAST_CONFIG, m_cfg); end
            checks++;
            CH_VALUES = rand_ch();   // already sampled; must not disturb this frame
            cfg = 6'($urandom);
            if (cfg[5] == 1'b0) cfg[1] = 1'b1;
            if ($urandom_range(0, 1) == 1) clk(100);
            cs_fall_wait();
            spi_bits(cfg, 12, d);
            if (d !== m_res) begin errors++; $display("FAIL rand_data it=%0d got=%h exp=%h", it, d, m_res); end
            checks++;
            if (FRAME_COUNT !== 16'(m_frames)) begin errors++; $display("FAIL rand_frames it=%0d got=%0d exp=%0d", it, FRAME_COUNT, m_frames); end
            checks++;
        end
        if (PROTO_ERR !== m_proto) begin errors++; $display("FAIL rand_proto got=%b exp=%b", PROTO_ERR, m_proto); end
        checks++;
    endtask

    initial begin
        CH_VALUES = '0;
        test_reset();
        test_basic();
        test_config_select();
        test_bipolar();
        test_early_cs();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
